// File: rtl/ucode_pkg.sv
// Shared encodings for the microprogrammed control unit.
// Sequencing modes (N field) and condition-source selects.
package ucode_pkg;

   localparam int STATE_W = 10;

   localparam logic [2:0] N_DECODE = 3'd0;
   localparam logic [2:0] N_FETCH  = 3'd1;
   localparam logic [2:0] N_JAL    = 3'd2;
   localparam logic [2:0] N_INCR   = 3'd3;
   localparam logic [2:0] N_BR_INC = 3'd4;
   localparam logic [2:0] N_BR_DEC = 3'd5;
   localparam logic [2:0] N_WAIT   = 3'd6;
   localparam logic [2:0] N_RET    = 3'd7;

   localparam logic [1:0] SEL_MOC  = 2'd0;
   localparam logic [1:0] SEL_COND = 2'd1;
   localparam logic [1:0] SEL_IRQ  = 2'd2;
   localparam logic [1:0] SEL_ONE  = 2'd3;

endpackage

// File: rtl/next_state_mux.sv
// Combinational next-microstate selection.
// Watchdog override is applied by the caller.
module next_state_mux
   import ucode_pkg::*;
#(
   parameter int W           = STATE_W,
   parameter int FETCH_STATE = 1
) (
   input  logic [2:0]   n,
   input  logic         t,
   input  logic [W-1:0] cr,
   input  logic [W-1:0] incr,
   input  logic [W-1:0] decode_addr,
   input  logic [W-1:0] link,
   input  logic [W-1:0] current_state,
   output logic [W-1:0] nxt
);

   always_comb begin
      nxt = current_state;
      unique case (n)
         N_DECODE: nxt = decode_addr;
         N_FETCH:  nxt = W'(FETCH_STATE);
         N_JAL:    nxt = cr;
         N_INCR:   nxt = incr;
         N_BR_INC: nxt = t ? cr : incr;
         N_BR_DEC: nxt = t ? cr : decode_addr;
         N_WAIT:   nxt = t ? incr : current_state;
         N_RET:    nxt = link;
         default:  nxt = current_state;
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: registered microstate address, link register
// and memory-wait watchdog feeding the control ROM.
module microsequencer
   import ucode_pkg::*;
#(
   parameter int SW          = STATE_W,
   parameter int RESET_STATE = 0,
   parameter int FETCH_STATE = 1,
   parameter int ERR_STATE   = 1023,
   parameter int WAIT_MAX    = 255,
   parameter int WAIT_CNT_W  = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    N,
   input  logic          inv,
   input  logic [1:0]    select,
   input  logic [SW-1:0] cr,
   input  logic          moc,
   input  logic          cond,
   input  logic          irq,
   input  logic [SW-1:0] decode_addr,
   output logic [SW-1:0] current_state,
   output logic [SW-1:0] link,
   output logic          mem_timeout
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
      WAIT_CNT_W'(WAIT_MAX - 1);

   logic                  c_sel;
   logic                  t;
   logic                  waiting;
   logic                  expire;
   logic [SW-1:0]         incr;
   logic [SW-1:0]         nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;

   always_comb begin
      c_sel = 1'b1;
      unique case (select)
         SEL_MOC:  c_sel = moc;
         SEL_COND: c_sel = cond;
         SEL_IRQ:  c_sel = irq;
         SEL_ONE:  c_sel = 1'b1;
         default:  c_sel = 1'b1;
      endcase
   end

   assign t       = c_sel ^ inv;
   assign incr    = current_state + 1'b1;
   assign waiting = (N == N_WAIT) && !t;
   assign expire  = waiting && (wait_cnt == WAIT_LAST);

   next_state_mux #(
      .W           (SW),
      .FETCH_STATE (FETCH_STATE)
   ) u_mux (
      .n             (N),
      .t             (t),
      .cr            (cr),
      .incr          (incr),
      .decode_addr   (decode_addr),
      .link          (link),
      .current_state (current_state),
      .nxt           (nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         current_state <= SW'(RESET_STATE);
         link          <= '0;
         wait_cnt      <= '0;
         mem_timeout   <= 1'b0;
      end else begin
         mem_timeout <= expire;
         // A stalled memory wait escapes to the error handler.
         if (expire) begin
            current_state <= SW'(ERR_STATE);
            wait_cnt      <= '0;
         end else begin
            current_state <= nxt;
            wait_cnt      <= waiting ? wait_cnt + 1'b1 : '0;
         end
         if (N == N_JAL)
            link <= incr;
      end
   end

endmodule
